// File: rtl/latch7475_ctrl_pkg.sv
// Shared types and constants for the 7475 quad-latch write controller.
//   state_t   : controller FSM states
//   CNT_W     : width of the shared per-state cycle counter
//   HALF_C1/2 : half-select encodings (0 -> c1/d1/d2, 1 -> c2/d3/d4)
//   cnt_load  : counter reload value for a state lasting 'cycles' cycles
package latch7475_ctrl_pkg;

  localparam int CNT_W = 4;

  localparam logic HALF_C1 = 1'b0;
  localparam logic HALF_C2 = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    ACK    = 3'd4
  } state_t;

  // The counter counts down to zero, so a state lasting N cycles loads N-1.
  function automatic logic [CNT_W-1:0] cnt_load(input int cycles);
    return CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/latch7475_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter.
//   clk, rst : clock and synchronous active-high reset
//   req[1:0] : request vector
//   advance  : commit the current grant (updates the last-grant register)
//   gnt[1:0] : one-hot grant, all-zero when nothing is requested
// On contention the requester not granted last wins. last_reg resets to 1
// so requester 0 wins the first contended arbitration.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic last_reg;

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = last_reg ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_reg <= 1'b1;
    end else if (advance && (gnt != 2'b00)) begin
      last_reg <= gnt[1];
    end
  end

endmodule

// File: rtl/latch7475_ctrl.sv
// Write controller sharing one 7475 quad latch between two requesters.
//   clk, rst          : clock and synchronous active-high reset
//   req0/1, sel0/1    : write request and target half (0 -> c1, 1 -> c2)
//   data0/1           : write data, bit0 -> d1/d3, bit1 -> d2/d4
//   ack0/1            : one-cycle completion pulse to the granted requester
//   d1..d4, c1, c2    : registered latch data and enable pins
//   busy              : high whenever the FSM is not in IDLE
// Sequence per write: IDLE (grant, load data) -> SETUP -> STROBE -> HOLD -> ACK.
// SETUP_CYCLES, EN_CYCLES and HOLD_CYCLES are legal in the range 1..15.
module latch7475_ctrl
  import latch7475_ctrl_pkg::*;
#(
  parameter int SETUP_CYCLES = 1,
  parameter int EN_CYCLES    = 1,
  parameter int HOLD_CYCLES  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic       sel0,
  input  logic       sel1,
  input  logic [1:0] data0,
  input  logic [1:0] data1,
  output logic       ack0,
  output logic       ack1,
  output logic       d1,
  output logic       d2,
  output logic       d3,
  output logic       d4,
  output logic       c1,
  output logic       c2,
  output logic       busy
);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             gnt_idx_reg;
  logic             sel_reg;
  logic [1:0]       ack_reg, ack_next;
  logic [1:0]       en_next;
  logic [1:0]       gnt;
  logic             grant_now;
  logic             win_idx;
  logic             win_sel;
  logic [1:0]       win_data;

  // A grant only happens from IDLE; a request dropped before this point
  // simply never shows up in gnt.
  assign grant_now = (state_reg == IDLE) && (gnt != 2'b00);

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     ({req1, req0}),
    .advance (grant_now),
    .gnt     (gnt)
  );

  assign win_idx  = gnt[1];
  assign win_sel  = win_idx ? sel1  : sel0;
  assign win_data = win_idx ? data1 : data0;

  // State register plus the per-transaction context captured at grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      gnt_idx_reg <= 1'b0;
      sel_reg     <= HALF_C1;
      ack_reg     <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      ack_reg   <= ack_next;
      if (grant_now) begin
        gnt_idx_reg <= win_idx;
        sel_reg     <= win_sel;
      end
    end
  end

  // Next-state logic; the shared counter is reloaded on every state entry.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    unique case (state_reg)
      IDLE: begin
        if (grant_now) begin
          state_next = SETUP;
          cnt_next   = cnt_load(SETUP_CYCLES);
        end
      end
      SETUP: begin
        if (cnt_reg == '0) begin
          state_next = STROBE;
          cnt_next   = cnt_load(EN_CYCLES);
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      STROBE: begin
        if (cnt_reg == '0) begin
          state_next = HOLD;
          cnt_next   = cnt_load(HOLD_CYCLES);
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      HOLD: begin
        if (cnt_reg == '0) begin
          state_next = ACK;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      ACK: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Outputs are decoded from state_next and registered, so the pins change
  // in the same cycle as the state and carry no decode glitches. Only one
  // bit of en_next can ever be set, keeping c1 and c2 mutually exclusive.
  always_comb begin
    en_next  = '0;
    ack_next = '0;
    if (state_next == STROBE) begin
      en_next[sel_reg] = 1'b1;
    end
    if (state_next == ACK) begin
      ack_next[gnt_idx_reg] = 1'b1;
    end
  end

  // One data/enable register set per latch half; index matches HALF_C1/HALF_C2.
  for (genvar gi = 0; gi < 2; gi++) begin : g_half
    logic [1:0] d_reg;
    logic       en_reg;

    always_ff @(posedge clk) begin
      if (rst) begin
        d_reg  <= '0;
        en_reg <= 1'b0;
      end else begin
        en_reg <= en_next[gi];
        // Only the targeted half is loaded; the other keeps its last value.
        if (grant_now && (win_sel == 1'(gi))) begin
          d_reg <= win_data;
        end
      end
    end
  end

  assign d1   = g_half[0].d_reg[0];
  assign d2   = g_half[0].d_reg[1];
  assign d3   = g_half[1].d_reg[0];
  assign d4   = g_half[1].d_reg[1];
  assign c1   = g_half[0].en_reg;
  assign c2   = g_half[1].en_reg;
  assign ack0 = ack_reg[0];
  assign ack1 = ack_reg[1];
  assign busy = (state_reg != IDLE);

endmodule

// File: tb/tb_latch7475_ctrl.sv
// Self-checking bench for latch7475_ctrl. Cycle n is the clock period that
// starts at rising edge n; inputs are driven just after that edge and
// outputs are sampled on the following falling edge.
module tb_latch7475_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       req0, req1, sel0, sel1;
  logic [1:0] data0, data1;
  logic       ack0, ack1, d1, d2, d3, d4, c1, c2, busy;

  // Second instance with stretched timing (3/2/2).
  logic       p_req0, p_req1, p_sel0, p_sel1;
  logic [1:0] p_data0, p_data1;
  logic       p_ack0, p_ack1, p_d1, p_d2, p_d3, p_d4, p_c1, p_c2, p_busy;

  latch7475_ctrl dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .sel0(sel0), .sel1(sel1),
    .data0(data0), .data1(data1),
    .ack0(ack0), .ack1(ack1),
    .d1(d1), .d2(d2), .d3(d3), .d4(d4),
    .c1(c1), .c2(c2), .busy(busy)
  );

  latch7475_ctrl #(.SETUP_CYCLES(3), .EN_CYCLES(2), .HOLD_CYCLES(2)) dut_p (
    .clk(clk), .rst(rst),
    .req0(p_req0), .req1(p_req1), .sel0(p_sel0), .sel1(p_sel1),
    .data0(p_data0), .data1(p_data1),
    .ack0(p_ack0), .ack1(p_ack1),
    .d1(p_d1), .d2(p_d2), .d3(p_d3), .d4(p_d4),
    .c1(p_c1), .c2(p_c2), .busy(p_busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // inp = {rst, req0, sel0, data0[1:0], req1, sel1, data1[1:0]}
  // exp = {chk, d4 d3 d2 d1, c2 c1, ack1 ack0, busy}
  typedef struct {
    logic [8:0] inp;
    logic [9:0] exp;
  } vec_t;

  localparam int NVEC = 31;
  vec_t vecs [NVEC];

  logic       retain_bad;
  logic       watch_d12;

  // Raise a request, wait (bounded) for its ack, then drop the request.
  task automatic do_write(input logic who, input logic s, input logic [1:0] dat, input string tag);
    logic seen;
    seen = 1'b0;
    if (who) begin req1 = 1'b1; sel1 = s; data1 = dat; end
    else     begin req0 = 1'b1; sel0 = s; data0 = dat; end
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (watch_d12 && ({d2, d1} !== 2'b01)) retain_bad = 1'b1;
      if (who ? ack1 : ack0) seen = 1'b1;
      tick();
    end
    req0 = 1'b0;
    req1 = 1'b0;
    check({tag, "_ack_seen"}, 32'(seen), 32'd1);
  endtask

  initial begin
    logic [8:0]  vi;
    logic [9:0]  ve;
    logic [15:0] c1_hist, c2_hist, ack_hist, busy_hist;
    logic        gnt_hist [4];
    int          n_ack;
    int          overlap;

    // Tests 1, 2 and 4 as per-cycle vectors.
    vecs[ 0] = '{9'b0_1_0_11_0_0_00, 10'b1_0000_00_00_0};
    vecs[ 1] = '{9'b0_1_0_11_0_0_00, 10'b1_0011_00_00_1};
    vecs[ 2] = '{9'b0_1_0_11_0_0_00, 10'b1_0011_01_00_1};
    vecs[ 3] = '{9'b0_1_0_11_0_0_00, 10'b1_0011_00_00_1};
    vecs[ 4] = '{9'b0_0_0_00_0_0_00, 10'b1_0011_00_01_1};
    vecs[ 5] = '{9'b0_0_0_00_0_0_00, 10'b1_0011_00_00_0};
    vecs[ 6] = '{9'b1_0_0_00_0_0_00, 10'b0_0000_00_00_0};
    vecs[ 7] = '{9'b0_1_1_01_1_0_10, 10'b1_0000_00_00_0};
    vecs[ 8] = '{9'b0_1_1_01_1_0_10, 10'b1_0100_00_00_1};
    vecs[ 9] = '{9'b0_1_1_01_1_0_10, 10'b1_0100_10_00_1};
    vecs[10] = '{9'b0_1_1_01_1_0_10, 10'b1_0100_00_00_1};
    vecs[11] = '{9'b0_0_0_00_1_0_10, 10'b1_0100_00_01_1};
    vecs[12] = '{9'b0_0_0_00_1_0_10, 10'b1_0100_00_00_0};
    vecs[13] = '{9'b0_0_0_00_1_0_10, 10'b1_0110_00_00_1};
    vecs[14] = '{9'b0_0_0_00_1_0_10, 10'b1_0110_01_00_1};
    vecs[15] = '{9'b0_0_0_00_1_0_10, 10'b1_0110_00_00_1};
    vecs[16] = '{9'b0_0_0_00_0_0_00, 10'b1_0110_00_10_1};
    vecs[17] = '{9'b0_0_0_00_0_0_00, 10'b1_0110_00_00_0};
    vecs[18] = '{9'b1_0_0_00_0_0_00, 10'b0_0000_00_00_0};
    vecs[19] = '{9'b0_1_0_01_0_0_00, 10'b1_0000_00_00_0};
    vecs[20] = '{9'b0_1_0_01_0_0_00, 10'b1_0001_00_00_1};
    vecs[21] = '{9'b1_1_0_01_0_0_00, 10'b1_0001_01_00_1};
    vecs[22] = '{9'b0_0_0_00_0_0_00, 10'b1_0000_00_00_0};
    vecs[23] = '{9'b0_0_0_00_0_0_00, 10'b1_0000_00_00_0};
    vecs[24] = '{9'b0_0_0_00_0_0_00, 10'b1_0000_00_00_0};
    vecs[25] = '{9'b0_0_0_00_1_1_11, 10'b1_0000_00_00_0};
    vecs[26] = '{9'b0_0_0_00_1_1_11, 10'b1_1100_00_00_1};
    vecs[27] = '{9'b0_0_0_00_1_1_11, 10'b1_1100_10_00_1};
    vecs[28] = '{9'b0_0_0_00_1_1_11, 10'b1_1100_00_00_1};
    vecs[29] = '{9'b0_0_0_00_0_0_00, 10'b1_1100_00_10_1};
    vecs[30] = '{9'b0_0_0_00_0_0_00, 10'b1_1100_00_00_0};

    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0; sel0 = 1'b0; sel1 = 1'b0; data0 = 2'b00; data1 = 2'b00;
    p_req0 = 1'b0; p_req1 = 1'b0; p_sel0 = 1'b0; p_sel1 = 1'b0; p_data0 = 2'b00; p_data1 = 2'b00;
    retain_bad = 1'b0;
    watch_d12 = 1'b0;
    tick();
    tick();

    for (int i = 0; i < NVEC; i++) begin
      vi = vecs[i].inp;
      ve = vecs[i].exp;
      rst   = vi[8];
      req0  = vi[7];
      sel0  = vi[6];
      data0 = vi[5:4];
      req1  = vi[3];
      sel1  = vi[2];
      data1 = vi[1:0];
      @(negedge clk);
      if (ve[9]) begin
        check($sformatf("vec%0d", i), 32'({d4, d3, d2, d1, c2, c1, ack1, ack0, busy}), 32'(ve[8:0]));
        $display("vec%0d: d4..d1=%b%b%b%b c2c1=%b%b ack1ack0=%b%b busy=%b",
                 i, d4, d3, d2, d1, c2, c1, ack1, ack0, busy);
      end
      tick();
    end
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0;

    // Test 3: both requests held continuously, grants must alternate 0,1,0,1.
    rst = 1'b1; tick(); rst = 1'b0;
    req0 = 1'b1; sel0 = 1'b0; data0 = 2'b01;
    req1 = 1'b1; sel1 = 1'b1; data1 = 2'b10;
    n_ack = 0;
    overlap = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (c1 && c2) overlap++;
      if (ack0 && ack1) overlap++;
      if ((ack0 || ack1) && n_ack < 4) begin
        gnt_hist[n_ack] = ack1;
        n_ack++;
        $display("rr: ack%0d in cycle %0d", ack1 ? 1 : 0, cyc);
      end
      tick();
    end
    req0 = 1'b0; req1 = 1'b0;
    check("rr_nacks", 32'(n_ack), 32'd4);
    check("rr_overlap", 32'(overlap), 32'd0);
    for (int i = 0; i < n_ack; i++) begin
      check($sformatf("rr_gnt%0d", i), 32'(gnt_hist[i]), 32'(i % 2));
    end
    tick(); tick();

    // Test 6: half 0 then half 1; half 0 must be retained.
    rst = 1'b1; tick(); rst = 1'b0;
    do_write(1'b0, 1'b0, 2'b01, "w_half0");
    @(negedge clk);
    check("w_after_half0", 32'({d4, d3, d2, d1}), 32'b0001);
    $display("w_half0: d4..d1=%b%b%b%b", d4, d3, d2, d1);
    tick();
    watch_d12 = 1'b1;
    do_write(1'b1, 1'b1, 2'b10, "w_half1");
    watch_d12 = 1'b0;
    @(negedge clk);
    check("w_retain_half0", 32'(retain_bad), 32'd0);
    check("w_final", 32'({d4, d3, d2, d1}), 32'b1001);
    $display("w_half1: d4..d1=%b%b%b%b", d4, d3, d2, d1);
    tick();

    // Test 5: stretched timing on the second instance.
    rst = 1'b1; tick(); rst = 1'b0;
    p_req0 = 1'b1; p_sel0 = 1'b0; p_data0 = 2'b10;
    c1_hist = '0; c2_hist = '0; ack_hist = '0; busy_hist = '0;
    for (int cyc = 0; cyc < 15; cyc++) begin
      @(negedge clk);
      c1_hist[cyc]   = p_c1;
      c2_hist[cyc]   = p_c2;
      ack_hist[cyc]  = p_ack0;
      busy_hist[cyc] = p_busy;
      tick();
      if (cyc >= 8) p_req0 = 1'b0;
    end
    $display("slow: c1=%h c2=%h ack=%h busy=%h", c1_hist, c2_hist, ack_hist, busy_hist);
    check("slow_c1", 32'(c1_hist), 32'h0030);
    check("slow_c2", 32'(c2_hist), 32'h0000);
    check("slow_ack", 32'(ack_hist), 32'h0100);
    check("slow_busy", 32'(busy_hist), 32'h01FE);
    check("slow_data", 32'({p_d4, p_d3, p_d2, p_d1}), 32'b0010);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
